// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage_if
// Description : Data-memory request/acknowledge bus between the MIPS memory
//               stage (master) and the data memory (slave).
//               dmem_req   - access request, held until dmem_ack
//               dmem_we    - 1 = write, 0 = read
//               dmem_addr  - word-aligned byte address
//               dmem_wdata - store data
//               dmem_be    - byte enables
//               dmem_rdata - load data, valid with dmem_ack
//               dmem_ack   - access complete
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_rdata, dmem_ack
   );
endinterface
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : MEM stage of the 5-stage MIPS pipeline. Resolves branch/jump
//               redirects, runs data-memory accesses over a req/ack bus with
//               a timeout, and registers results into MEM/WB. All state
//               updates on the falling edge of clk.
// Ports       : clk, Reset         - clock (negedge active), sync reset
//               *_in               - EX/MEM register fields
//               dmem               - data-memory bus (master side)
//               stall_out          - hold upstream while access outstanding
//               Redirect_out       - one-cycle PC load pulse
//               PC_target_out      - redirect target
//               Result_out, RegWr_out, Rd_out, Rd_write_by_en_out - MEM/WB
//               Bus_error_out      - sticky timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic [31:0] PC_Branch_in,
   input  logic [31:0] PC_Jump_in,
   input  logic [31:0] ALUShift_out_in,
   input  logic [31:0] MemData_in,
   input  logic [3:0]  StoreBE_in,
   input  logic [3:0]  Rd_write_by_en_in,
   input  logic        MemRead_in,
   input  logic        MemWrite_in,
   input  logic        Jump_in,
   input  logic        Less_in,
   input  logic        Zero_in,
   input  logic        Overflow_in,
   input  logic        RegWr_in,
   input  logic [2:0]  Condition_in,
   input  logic [4:0]  Rd_in,
   mem_access_stage_if.master dmem,
   output logic        stall_out,
   output logic        Redirect_out,
   output logic [31:0] PC_target_out,
   output logic [31:0] Result_out,
   output logic        RegWr_out,
   output logic [4:0]  Rd_out,
   output logic [3:0]  Rd_write_by_en_out,
   output logic        Bus_error_out
);

   localparam logic [0:0] c_IDLE     = 1'b0;
   localparam logic [0:0] c_WAIT     = 1'b1;
   localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

   logic [0:0]  r_state;
   logic [0:0]  w_state_nxt;
   logic [7:0]  r_cnt;

   // Access captured on entry to WAIT
   logic [31:0] r_addr;      // full ALU value: address, and result of a store
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic        r_we;
   logic        r_load;
   logic [4:0]  r_rd;
   logic        r_regwr;
   logic [3:0]  r_rdwe;

   logic        w_taken;
   logic        w_redirect;
   logic [31:0] w_target;
   logic        w_mem_op;
   logic        w_is_load;
   logic        w_regwr;
   logic [3:0]  w_be_in;
   logic        w_ack;
   logic        w_timeout;
   logic        w_go_wait;

   // ------------------------------------------------------------------------
   // Branch resolution
   // ------------------------------------------------------------------------
   always_comb begin
      w_taken = 1'b0;
      case (Condition_in)
         3'b001:  w_taken = Zero_in;
         3'b010:  w_taken = ~Zero_in;
         3'b011:  w_taken = Less_in | Zero_in;
         3'b100:  w_taken = ~Less_in & ~Zero_in;
         3'b101:  w_taken = Less_in;
         3'b110:  w_taken = ~Less_in;
         default: w_taken = 1'b0;
      endcase
   end

   assign w_redirect = Jump_in | w_taken;
   assign w_target   = Jump_in ? PC_Jump_in : PC_Branch_in;

   // A simultaneous read+write is a write, so a load needs MemWrite_in low
   assign w_mem_op  = MemRead_in | MemWrite_in;
   assign w_is_load = MemRead_in & ~MemWrite_in;
   assign w_regwr   = RegWr_in & ~Overflow_in;
   assign w_be_in   = MemWrite_in ? StoreBE_in : 4'b1111;
   assign w_ack     = dmem.dmem_ack;
   assign w_timeout = (r_cnt == c_CNT_LAST) & ~w_ack;
   assign w_go_wait = w_mem_op & ~w_ack;

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(negedge clk) begin
      if (Reset) r_state <= c_IDLE;
      else       r_state <= w_state_nxt;
   end

   // ------------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (w_go_wait)           w_state_nxt = c_WAIT;
         c_WAIT:  if (w_ack || w_timeout)  w_state_nxt = c_IDLE;
         default:                          w_state_nxt = c_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs. IDLE drives the bus straight from EX/MEM so a zero-wait
   // memory completes without a stall; WAIT drives from captured registers
   // so the bus stays stable whatever upstream presents.
   // ------------------------------------------------------------------------
   always_comb begin
      dmem.dmem_req   = 1'b0;
      dmem.dmem_we    = 1'b0;
      dmem.dmem_addr  = {ALUShift_out_in[31:2], 2'b00};
      dmem.dmem_wdata = MemData_in;
      dmem.dmem_be    = w_be_in;
      stall_out       = 1'b0;
      case (r_state)
         c_IDLE: begin
            dmem.dmem_req = w_mem_op;
            dmem.dmem_we  = MemWrite_in;
            stall_out     = w_go_wait;
         end
         c_WAIT: begin
            dmem.dmem_req   = 1'b1;
            dmem.dmem_we    = r_we;
            dmem.dmem_addr  = {r_addr[31:2], 2'b00};
            dmem.dmem_wdata = r_wdata;
            dmem.dmem_be    = r_be;
            stall_out       = ~w_ack;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------------
   // MEM/WB register, capture registers and timeout counter
   // ------------------------------------------------------------------------
   always_ff @(negedge clk) begin
      if (Reset) begin
         r_cnt              <= 8'd0;
         r_addr             <= 32'd0;
         r_wdata            <= 32'd0;
         r_be               <= 4'd0;
         r_we               <= 1'b0;
         r_load             <= 1'b0;
         r_rd               <= 5'd0;
         r_regwr            <= 1'b0;
         r_rdwe             <= 4'd0;
         Result_out         <= 32'd0;
         RegWr_out          <= 1'b0;
         Rd_out             <= 5'd0;
         Rd_write_by_en_out <= 4'd0;
         Redirect_out       <= 1'b0;
         PC_target_out      <= 32'd0;
         Bus_error_out      <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               r_cnt <= 8'd0;
               if (w_go_wait) begin
                  r_addr       <= ALUShift_out_in;
                  r_wdata      <= MemData_in;
                  r_be         <= w_be_in;
                  r_we         <= MemWrite_in;
                  r_load       <= w_is_load;
                  r_rd         <= Rd_in;
                  r_regwr      <= w_regwr;
                  r_rdwe       <= Rd_write_by_en_in;
                  RegWr_out    <= 1'b0;
                  Redirect_out <= 1'b0;
               end else begin
                  // w_is_load implies a mem op, which here has its ack
                  Result_out         <= w_is_load ? dmem.dmem_rdata : ALUShift_out_in;
                  RegWr_out          <= w_regwr;
                  Rd_out             <= Rd_in;
                  Rd_write_by_en_out <= Rd_write_by_en_in;
                  Redirect_out       <= w_redirect;
                  if (w_redirect) PC_target_out <= w_target;
               end
            end
            c_WAIT: begin
               Redirect_out <= 1'b0;
               if (w_ack) begin
                  Result_out         <= r_load ? dmem.dmem_rdata : r_addr;
                  RegWr_out          <= r_regwr;
                  Rd_out             <= r_rd;
                  Rd_write_by_en_out <= r_rdwe;
                  r_cnt              <= 8'd0;
               end else if (w_timeout) begin
                  RegWr_out     <= 1'b0;
                  Bus_error_out <= 1'b1;
                  r_cnt         <= 8'd0;
               end else begin
                  RegWr_out <= 1'b0;
                  r_cnt     <= r_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Self-checking bench for mem_access_stage. Single-cycle
//               behaviour from a vector table; wait-state load, timeout and
//               reset-during-WAIT as directed sequences. Inputs change 1 time
//               unit after the falling (active) edge, outputs are sampled on
//               the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

   localparam int c_TO = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        Reset;
   logic [31:0] PC_Branch_in, PC_Jump_in, ALUShift_out_in, MemData_in;
   logic [3:0]  StoreBE_in, Rd_write_by_en_in;
   logic        MemRead_in, MemWrite_in, Jump_in, Less_in, Zero_in, Overflow_in, RegWr_in;
   logic [2:0]  Condition_in;
   logic [4:0]  Rd_in;
   logic        stall_out, Redirect_out, RegWr_out, Bus_error_out;
   logic [31:0] PC_target_out, Result_out;
   logic [4:0]  Rd_out;
   logic [3:0]  Rd_write_by_en_out;

   mem_access_stage_if dmem_bus();

   mem_access_stage #(.TIMEOUT(c_TO)) dut (
      .clk                (clk),
      .Reset              (Reset),
      .PC_Branch_in       (PC_Branch_in),
      .PC_Jump_in         (PC_Jump_in),
      .ALUShift_out_in    (ALUShift_out_in),
      .MemData_in         (MemData_in),
      .StoreBE_in         (StoreBE_in),
      .Rd_write_by_en_in  (Rd_write_by_en_in),
      .MemRead_in         (MemRead_in),
      .MemWrite_in        (MemWrite_in),
      .Jump_in            (Jump_in),
      .Less_in            (Less_in),
      .Zero_in            (Zero_in),
      .Overflow_in        (Overflow_in),
      .RegWr_in           (RegWr_in),
      .Condition_in       (Condition_in),
      .Rd_in              (Rd_in),
      .dmem               (dmem_bus),
      .stall_out          (stall_out),
      .Redirect_out       (Redirect_out),
      .PC_target_out      (PC_target_out),
      .Result_out         (Result_out),
      .RegWr_out          (RegWr_out),
      .Rd_out             (Rd_out),
      .Rd_write_by_en_out (Rd_write_by_en_out),
      .Bus_error_out      (Bus_error_out)
   );

   typedef struct {
      logic [2:0]  cond;
      logic        zero, less, jump;
      logic [31:0] pcb, pcj, alu;
      logic        regwr;
      logic [4:0]  rd;
      logic [3:0]  rdwe;
      logic        ovf, mrd, mwr;
      logic [3:0]  sbe;
      logic [31:0] wdata;
      logic        ack;
      logic [31:0] rdata;
      // expected
      logic        e_req, e_we;
      logic [3:0]  e_be;
      logic [31:0] e_addr;
      logic        e_stall;
      logic [31:0] e_res;
      logic        e_regwr, e_redir;
      logic [31:0] e_tgt;
   } vec_t;

   localparam int c_NV = 19;
   vec_t v [c_NV];

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      PC_Branch_in = 32'h0; PC_Jump_in = 32'h0; ALUShift_out_in = 32'h0; MemData_in = 32'h0;
      StoreBE_in = 4'h0; Rd_write_by_en_in = 4'h0; MemRead_in = 1'b0; MemWrite_in = 1'b0;
      Jump_in = 1'b0; Less_in = 1'b0; Zero_in = 1'b0; Overflow_in = 1'b0; RegWr_in = 1'b0;
      Condition_in = 3'd0; Rd_in = 5'd0;
      dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = 32'h0;
   endtask

   task automatic apply(input vec_t t);
      Condition_in = t.cond; Zero_in = t.zero; Less_in = t.less; Jump_in = t.jump;
      PC_Branch_in = t.pcb; PC_Jump_in = t.pcj; ALUShift_out_in = t.alu;
      RegWr_in = t.regwr; Rd_in = t.rd; Rd_write_by_en_in = t.rdwe; Overflow_in = t.ovf;
      MemRead_in = t.mrd; MemWrite_in = t.mwr; StoreBE_in = t.sbe; MemData_in = t.wdata;
      dmem_bus.dmem_ack = t.ack; dmem_bus.dmem_rdata = t.rdata;
   endtask

   task automatic next_drive();
      @(negedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " Result_out"},    Result_out, 32'h0);
      chk({tag, " RegWr_out"},     {31'h0, RegWr_out}, 32'h0);
      chk({tag, " Rd_out"},        {27'h0, Rd_out}, 32'h0);
      chk({tag, " Rd_wbe_out"},    {28'h0, Rd_write_by_en_out}, 32'h0);
      chk({tag, " Redirect_out"},  {31'h0, Redirect_out}, 32'h0);
      chk({tag, " PC_target_out"}, PC_target_out, 32'h0);
      chk({tag, " Bus_error_out"}, {31'h0, Bus_error_out}, 32'h0);
      chk({tag, " dmem_req"},      {31'h0, dmem_bus.dmem_req}, 32'h0);
      chk({tag, " stall_out"},     {31'h0, stall_out}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int stalls;
      int wst;

      // cond zero less jump | pcb pcj alu | regwr rd rdwe ovf mrd mwr sbe wdata ack rdata
      //   || e_req e_we e_be e_addr e_stall | e_res e_regwr e_redir e_tgt
      v[0]  = '{3'd0,1'b0,1'b0,1'b0, 32'h0,32'h0,32'h1234, 1'b1,5'd5,4'hF,1'b0,1'b0,1'b0,4'h0,32'h0,1'b0,32'h0,
                1'b0,1'b0,4'h0,32'h0,1'b0, 32'h1234,1'b1,1'b0,32'h0};
      v[1]  = '{3'd1,1'b1,1'b0,1'b0, 32'h40,32'h0,32'h0, 1'b0,5'd0,4'h0,1'b0,1'b0,1'b0,4'h0,32'h0,1'b0,32'h0,
                1'b0,1'b0,4'h0,32'h0,1'b0, 32'h0,1'b0,1'b1,32'h40};
      v[2]  = '{3'd1,1'b1,1'b0,1'b1, 32'h40,32'h80,32'h0, 1'b0,5'd0,4'h0,1'b0,1'b0,1'b0,4'h0,32'h0,1'b0,32'h0,
                1'b0,1'b0,4'h0,32'h0,1'b0, 32'h0,1'b0,1'b1,32'h80};
      v[3]  = '{3'd7,1'b1,1'b1,1'b0, 32'h40,32'h0,32'h0, 1'b0,5'd0,4'h0,1'b0,1'b0,1'b0,4'h0,32'h0,1'b0,32'h0,
                1'b0,1'b0,4'h0,32'h0,1'b0, 32'h0,1'b0,1'b0,32'h0};
      v[4]  = '{3'd2,1'b0,1'b0,1'b0, 32'h44,32'h0,32'h0, 1'b0,5'd0,4'h0,1'b0,1'b0,1'b0,4'h0,32'h0,1'b0,32'h0,
                1'b0,1'b0,4'h0,32'h0,1'b0, 32'h0,1'b0,1'b1,32'h44};
      v[5]  = '{3'd3,1'b0,1'b1,1'b0, 32'h48,32'h0,32'h0, 1'b0,5'd0,4'h0,1'b0,1'b0,1'b0,4'h0,32'h0,1'b0,32'h0,
                1'b0,1'b0,4'h0,32'h0,1'b0, 32'h0,1'b0,1'b1,32'h48};
      v[6]  = '{3'd4,1'b0,1'b0,1'b0, 32'h4C,32'h0,32'h0, 1'b0,5'd0,4'h0,1'b0,1'b0,1'b0,4'h0,32'h0,1'b0,32'h0,
                1'b0,1'b0,4'h0,32'h0,1'b0, 32'h0,1'b0,1'b1,32'h4C};
      v[7]  = '{3'd4,1'b1,1'b0,1'b0, 32'h4C,32'h0,32'h0, 1'b0,5'd0,4'h0,1'b0,1'b0,1'b0,4'h0,32'h0,1'b0,32'h0,
                1'b0,1'b0,4'h0,32'h0,1'b0, 32'h0,1'b0,1'b0,32'h0};
      v[8]  = '{3'd5,1'b0,1'b1,1'b0, 32'h50,32'h0,32'h0, 1'b0,5'd0,4'h0,1'b0,1'b0,1'b0,4'h0,32'h0,1'b0,32'h0,
                1'b0,1'b0,4'h0,32'h0,1'b0, 32'h0,1'b0,1'b1,32'h50};
      v[9]  = '{3'd6,1'b0,1'b1,1'b0, 32'h54,32'h0,32'h0, 1'b0,5'd0,4'h0,1'b0,1'b0,1'b0,4'h0,32'h0,1'b0,32'h0,
                1'b0,1'b0,4'h0,32'h0,1'b0, 32'h0,1'b0,1'b0,32'h0};
      v[10] = '{3'd6,1'b0,1'b0,1'b0, 32'h58,32'h0,32'h0, 1'b0,5'd0,4'h0,1'b0,1'b0,1'b0,4'h0,32'h0,1'b0,32'h0,
                1'b0,1'b0,4'h0,32'h0,1'b0, 32'h0,1'b0,1'b1,32'h58};
      v[11] = '{3'd1,1'b0,1'b0,1'b0, 32'h5C,32'h0,32'h0, 1'b0,5'd0,4'h0,1'b0,1'b0,1'b0,4'h0,32'h0,1'b0,32'h0,
                1'b0,1'b0,4'h0,32'h0,1'b0, 32'h0,1'b0,1'b0,32'h0};
      v[12] = '{3'd0,1'b1,1'b1,1'b0, 32'h60,32'h0,32'h0, 1'b0,5'd0,4'h0,1'b0,1'b0,1'b0,4'h0,32'h0,1'b0,32'h0,
                1'b0,1'b0,4'h0,32'h0,1'b0, 32'h0,1'b0,1'b0,32'h0};
      v[13] = '{3'd0,1'b0,1'b0,1'b1, 32'h0,32'h100,32'h0, 1'b0,5'd0,4'h0,1'b0,1'b0,1'b0,4'h0,32'h0,1'b0,32'h0,
                1'b0,1'b0,4'h0,32'h0,1'b0, 32'h0,1'b0,1'b1,32'h100};
      v[14] = '{3'd0,1'b0,1'b0,1'b0, 32'h0,32'h0,32'h55, 1'b1,5'd7,4'h1,1'b1,1'b0,1'b0,4'h0,32'h0,1'b0,32'h0,
                1'b0,1'b0,4'h0,32'h0,1'b0, 32'h55,1'b0,1'b0,32'h0};
      v[15] = '{3'd0,1'b0,1'b0,1'b0, 32'h0,32'h0,32'h207, 1'b0,5'd0,4'h0,1'b0,1'b0,1'b1,4'h3,32'hAABBCCDD,1'b1,32'h0,
                1'b1,1'b1,4'h3,32'h204,1'b0, 32'h207,1'b0,1'b0,32'h0};
      v[16] = '{3'd0,1'b0,1'b0,1'b0, 32'h0,32'h0,32'h13, 1'b1,5'd9,4'hF,1'b0,1'b1,1'b0,4'h0,32'h0,1'b1,32'h12345678,
                1'b1,1'b0,4'hF,32'h10,1'b0, 32'h12345678,1'b1,1'b0,32'h0};
      v[17] = '{3'd0,1'b0,1'b0,1'b0, 32'h0,32'h0,32'h20, 1'b1,5'd3,4'hF,1'b0,1'b1,1'b1,4'hC,32'h0BADF00D,1'b1,32'hFFFF,
                1'b1,1'b1,4'hC,32'h20,1'b0, 32'h20,1'b1,1'b0,32'h0};
      v[18] = '{3'd0,1'b0,1'b0,1'b0, 32'h0,32'h0,32'h99, 1'b1,5'd2,4'h2,1'b0,1'b0,1'b0,4'h0,32'h0,1'b1,32'h11,
                1'b0,1'b0,4'h0,32'h0,1'b0, 32'h99,1'b1,1'b0,32'h0};

      // ---------------- reset state ----------------
      Reset = 1'b1;
      idle_inputs();
      repeat (2) @(negedge clk);
      #1 Reset = 1'b0;
      @(posedge clk);
      check_all_zero("reset");

      // ---------------- table: one op, then one idle cycle ----------------
      for (int i = 0; i < c_NV; i++) begin
         next_drive();
         apply(v[i]);
         @(posedge clk);
         chk($sformatf("v%0d dmem_req", i),  {31'h0, dmem_bus.dmem_req}, {31'h0, v[i].e_req});
         chk($sformatf("v%0d stall_out", i), {31'h0, stall_out}, {31'h0, v[i].e_stall});
         chk($sformatf("v%0d redirect_prev_dropped", i), {31'h0, Redirect_out}, 32'h0);
         if (v[i].e_req) begin
            chk($sformatf("v%0d dmem_we", i),   {31'h0, dmem_bus.dmem_we}, {31'h0, v[i].e_we});
            chk($sformatf("v%0d dmem_be", i),   {28'h0, dmem_bus.dmem_be}, {28'h0, v[i].e_be});
            chk($sformatf("v%0d dmem_addr", i), dmem_bus.dmem_addr, v[i].e_addr);
            if (v[i].e_we) chk($sformatf("v%0d dmem_wdata", i), dmem_bus.dmem_wdata, v[i].wdata);
         end
         next_drive();
         idle_inputs();
         @(posedge clk);
         chk($sformatf("v%0d Result_out", i),   Result_out, v[i].e_res);
         chk($sformatf("v%0d RegWr_out", i),    {31'h0, RegWr_out}, {31'h0, v[i].e_regwr});
         chk($sformatf("v%0d Rd_out", i),       {27'h0, Rd_out}, {27'h0, v[i].rd});
         chk($sformatf("v%0d Rd_wbe_out", i),   {28'h0, Rd_write_by_en_out}, {28'h0, v[i].rdwe});
         chk($sformatf("v%0d Redirect_out", i), {31'h0, Redirect_out}, {31'h0, v[i].e_redir});
         if (v[i].e_redir) chk($sformatf("v%0d PC_target_out", i), PC_target_out, v[i].e_tgt);
      end
      chk("table Bus_error_out", {31'h0, Bus_error_out}, 32'h0);

      // ---------------- load acked in the 3rd WAIT cycle ----------------
      stalls = 0;
      next_drive();
      MemRead_in = 1'b1; ALUShift_out_in = 32'h103; RegWr_in = 1'b1; Rd_in = 5'd10;
      Rd_write_by_en_in = 4'h3;
      @(posedge clk);
      if (stall_out) stalls++;
      chk("ld0 dmem_req",  {31'h0, dmem_bus.dmem_req}, 32'h1);
      chk("ld0 dmem_addr", dmem_bus.dmem_addr, 32'h100);
      chk("ld0 dmem_be",   {28'h0, dmem_bus.dmem_be}, 32'hF);
      for (int w = 1; w <= 2; w++) begin
         next_drive();
         idle_inputs();
         ALUShift_out_in = 32'hFFFF_FFF0;   // upstream garbage must not reach the bus
         @(posedge clk);
         if (stall_out) stalls++;
         chk($sformatf("ld w%0d dmem_req", w),  {31'h0, dmem_bus.dmem_req}, 32'h1);
         chk($sformatf("ld w%0d dmem_addr", w), dmem_bus.dmem_addr, 32'h100);
         chk($sformatf("ld w%0d dmem_we", w),   {31'h0, dmem_bus.dmem_we}, 32'h0);
         chk($sformatf("ld w%0d bubble", w),    {31'h0, RegWr_out}, 32'h0);
      end
      next_drive();
      dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'hDEADBEEF;
      @(posedge clk);
      if (stall_out) stalls++;
      chk("ld ack dmem_addr", dmem_bus.dmem_addr, 32'h100);
      chk("ld stall_cycles",  stalls, 32'd3);
      next_drive();
      idle_inputs();
      @(posedge clk);
      chk("ld Result_out", Result_out, 32'hDEADBEEF);
      chk("ld RegWr_out",  {31'h0, RegWr_out}, 32'h1);
      chk("ld Rd_out",     {27'h0, Rd_out}, 32'd10);
      chk("ld Rd_wbe_out", {28'h0, Rd_write_by_en_out}, 32'h3);
      chk("ld dmem_req after", {31'h0, dmem_bus.dmem_req}, 32'h0);

      // ---------------- timeout: ack never arrives ----------------
      next_drive();
      MemWrite_in = 1'b1; StoreBE_in = 4'h5; ALUShift_out_in = 32'h300; MemData_in = 32'h1;
      @(posedge clk);
      chk("to0 stall_out", {31'h0, stall_out}, 32'h1);
      next_drive();
      idle_inputs();
      wst = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         if (!dmem_bus.dmem_req) break;
         if (stall_out) wst++;
         chk($sformatf("to c%0d dmem_addr", c), dmem_bus.dmem_addr, 32'h300);
         chk($sformatf("to c%0d dmem_be", c),   {28'h0, dmem_bus.dmem_be}, 32'h5);
         chk($sformatf("to c%0d Bus_error", c), {31'h0, Bus_error_out}, 32'h0);
         next_drive();
      end
      chk("to wait_stall_cycles", wst, c_TO);
      chk("to Bus_error_out", {31'h0, Bus_error_out}, 32'h1);
      chk("to stall_out",     {31'h0, stall_out}, 32'h0);
      chk("to RegWr_out",     {31'h0, RegWr_out}, 32'h0);

      // sticky error, stage back in IDLE
      next_drive();
      ALUShift_out_in = 32'h77; RegWr_in = 1'b1; Rd_in = 5'd4;
      next_drive();
      idle_inputs();
      @(posedge clk);
      chk("post-to Result_out",   Result_out, 32'h77);
      chk("post-to Bus_error",    {31'h0, Bus_error_out}, 32'h1);

      // ---------------- reset during WAIT ----------------
      next_drive();
      MemRead_in = 1'b1; ALUShift_out_in = 32'h400; RegWr_in = 1'b1; Rd_in = 5'd11;
      next_drive();
      idle_inputs();
      Reset = 1'b1;
      @(posedge clk);
      chk("rstw in WAIT req", {31'h0, dmem_bus.dmem_req}, 32'h1);
      next_drive();
      Reset = 1'b0;
      @(posedge clk);
      check_all_zero("rstw");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage of the 5-stage MIPS pipeline. Consumes the EX/MEM register outputs, resolves branch/jump redirects, performs data-memory loads and stores over a req/ack handshake with a timeout, and registers results into the MEM/WB boundary. Stalls the upstream pipeline while a memory access is outstanding.

## Interface
- TIMEOUT, 16: maximum cycles spent in WAIT before the access is aborted; valid range 2..255.
- clk  in  1  pipeline clock; all state updates on the falling edge.
- Reset  in  1  synchronous, active-high.
- PC_Branch_in, PC_Jump_in  in  32 each  branch and jump targets.
- ALUShift_out_in  in  32  ALU/shift result; this is the memory address for loads and stores.
- MemData_in  in  32  store data.
- StoreBE_in  in  4  store byte enables.
- Rd_write_by_en_in  in  4  register byte-write enables, passed through.
- MemRead_in, MemWrite_in, Jump_in, Less_in, Zero_in, Overflow_in, RegWr_in  in  1 each  control and flag inputs.
- Condition_in  in  3  branch condition code.
- Rd_in  in  5  destination register.
- dmem_req, dmem_we  out  1 each  memory request and write strobe.
- dmem_addr  out  32  word-aligned address, {addr[31:2], 2'b00}.
- dmem_wdata  out  32  store data.
- dmem_be  out  4  byte enables.
- dmem_rdata  in  32  read data.
- dmem_ack  in  1  access complete.
- stall_out  out  1  hold upstream stages.
- Redirect_out  out  1  one-cycle pulse: PC must load PC_target_out.
- PC_target_out  out  32  redirect target.
- Result_out  out  32  writeback value.
- RegWr_out  out  1  register write enable.
- Rd_out  out  5  destination register.
- Rd_write_by_en_out  out  4  byte-write enables.
- Bus_error_out  out  1  sticky; set on timeout.

## Operation
- Branch condition codes:
  - 000 none.
  - 001 taken when Zero.
  - 010 taken when !Zero.
  - 011 taken when Less|Zero.
  - 100 taken when !Less&!Zero.
  - 101 taken when Less.
  - 110 taken when !Less.
  - 111 reserved, never taken.
- Redirect selection: Jump_in overrides any branch and uses PC_Jump_in. Otherwise a taken branch uses PC_Branch_in.
- Overflow_in=1 forces RegWr_out=0 for that instruction. Nothing else changes.
- Mem op = MemRead_in|MemWrite_in. If both are set, the access is treated as a write.
- Address low bits [1:0] are ignored.
- Load: Result_out=dmem_rdata. Non-load: Result_out=ALUShift_out_in.
- FSM has two states, IDLE and WAIT.
- IDLE, no mem op:
  - Register the MEM/WB fields and the redirect at the next edge.
  - stall_out=0.
- IDLE, mem op:
  - Drive dmem_req=1 combinationally from the inputs.
  - dmem_be = StoreBE_in for writes, 4'b1111 for reads.
  - If dmem_ack=1 in the same cycle: complete at the next edge, stall_out=0.
  - Otherwise: stall_out=1; at the next edge capture addr, wdata, be, we, Rd, RegWr, Rd_write_by_en and the op type into internal registers; load the timeout counter with 0; go to WAIT.
- WAIT:
  - dmem_req=1, driven from the captured registers. stall_out=!dmem_ack.
  - MEM/WB outputs hold a bubble (RegWr_out=0) each edge while waiting.
  - On dmem_ack: at the next edge register the completed result (captured fields, with load data if a read) and return to IDLE.
  - Counter increments each edge without ack. If the counter reaches TIMEOUT-1 without ack: next edge emits a bubble, sets Bus_error_out, returns to IDLE, and drops dmem_req.
- Stores complete with RegWr_out=RegWr_in after overflow masking; this is normally 0.
- dmem_ack with dmem_req=0 is ignored.
- Bus_error_out clears only on Reset.

## Timing
- Latency: non-memory and zero-wait accesses appear on the MEM/WB outputs one falling edge after presentation. An access acked in the k-th WAIT cycle appears k+1 edges after presentation.
- Redirect_out is high for exactly one cycle after the registering edge. Redirects are never produced from WAIT, because branches carry no mem op.
- Reset (sampled on the falling edge, takes priority over everything):
  - State returns to IDLE and the counter clears.
  - All registered outputs go to 0: Result_out, RegWr_out, Rd_out, Rd_write_by_en_out, Redirect_out, PC_target_out, Bus_error_out.
  - dmem_req and stall_out are 0 in the cycle after reset.
  - Reset during WAIT aborts the access without an error.
- dmem_addr, dmem_wdata and dmem_be are stable for the whole time dmem_req=1 in WAIT.

## Test plan
- ALU op: ALUShift_out_in=0x1234, RegWr_in=1, Rd_in=5, no mem op -> next edge Result_out=0x1234, RegWr_out=1, Rd_out=5, stall_out=0.
- Branch/jump:
  - Condition_in=001, Zero_in=1, PC_Branch_in=0x40 -> Redirect_out pulses 1 cycle with PC_target_out=0x40.
  - Same inputs plus Jump_in=1, PC_Jump_in=0x80 -> PC_target_out=0x80.
  - Condition_in=111 -> no redirect.
- Load with 3 wait cycles: MemRead_in=1, addr=0x103, dmem_ack delayed 3 cycles, rdata=0xDEADBEEF:
  - dmem_addr=0x100 throughout.
  - stall_out high for 3 cycles.
  - Bubbles on MEM/WB, then Result_out=0xDEADBEEF with RegWr_out=1.
- Zero-wait store: MemWrite_in=1, StoreBE_in=0011, data=0xAABBCCDD, ack immediate -> dmem_we=1, dmem_be=0011, no stall.
- Timeout with TIMEOUT=4, ack never asserted -> exactly 4 stall cycles, then Bus_error_out=1, dmem_req=0, state IDLE.
- Reset in WAIT and overflow:
  - Reset asserted mid-access -> next edge all outputs 0, dmem_req=0, Bus_error_out=0.
  - Separately, Overflow_in=1 with RegWr_in=1 -> RegWr_out=0.
